giraffe_uart_tx: RTL and testbench

- Serial-side responder to the Giraffe capture FSM's byte write interface (wreq/wdata/uart_rdy).
- Buffers accepted bytes in a small FIFO and serialises each one onto an 8N1 UART line to the host.
- Provides the uart_rdy flow-control signal the FSM waits on, plus busy and sticky overflow status.

---
 rtl/giraffe_uart_pkg.sv | 21 ++
 rtl/giraffe_uart_tx_if.sv | 11 +
 rtl/giraffe_byte_fifo.sv | 51 +++++
 rtl/giraffe_uart_tx.sv | 116 +++++++++++
 tb/tb_giraffe_uart_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/giraffe_uart_pkg.sv
// Shared definitions for the Giraffe UART transmitter slice.
package giraffe_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // 50 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_t;

endpackage

// File: rtl/giraffe_uart_tx_if.sv
// Byte write handshake between the capture FSM (master) and the UART transmitter (slave).
interface giraffe_uart_tx_if #(
  parameter int N_data = 8
);
  logic              wreq;
  logic [N_data-1:0] wdata;
  logic              uart_rdy;

  modport master (output wreq, output wdata, input  uart_rdy);
  modport slave  (input  wreq, input  wdata, output uart_rdy);
endinterface

// File: rtl/giraffe_byte_fifo.sv
// Small first-word-fall-through byte FIFO; dout always shows the head entry.
module giraffe_byte_fifo #(
  parameter int N_data = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [N_data-1:0]          din,
  output logic [N_data-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [N_data-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  // Guard against over/underflow even if a caller misbehaves.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Storage is only written on an accepted push, so X on din otherwise never lands here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/giraffe_uart_tx.sv
// 8N1 UART transmitter fed through a small FIFO from the capture FSM.
module giraffe_uart_tx
  import giraffe_uart_pkg::*;
#(
  parameter int N_data       = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = 4
) (
  input  logic                clk,
  input  logic                nrst,
  giraffe_uart_tx_if.slave    bus,
  output logic                tx,
  output logic                busy,
  output logic                ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (N_data > 1) ? $clog2(N_data) : 1;

  uart_state_t       state;
  logic [TW-1:0]     timer;
  logic [BW-1:0]     bit_idx;
  logic [N_data-1:0] shift;
  logic [N_data-1:0] head;
  logic [AW:0]       count;
  logic              full, empty;
  logic              push, pop, bit_end;

  assign bus.uart_rdy = (count != (AW+1)'(DEPTH));
  assign push    = bus.wreq & bus.uart_rdy;
  assign bit_end = (timer == TW'(CLKS_PER_BIT-1));
  // Pop from IDLE, or at the very last stop-bit cycle for gapless back-to-back frames.
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign busy    = (state != IDLE) | ~empty;

  giraffe_byte_fifo #(.N_data(N_data), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .din   (bus.wdata),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow: a write attempted while the FIFO is full is dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                ovf <= 1'b0;
    else if (bus.wreq & full) ovf <= 1'b1;
  end

  // Frame FSM; tx is registered so each bit starts on a clean edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      tx      <= UART_IDLE_LEVEL;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          tx    <= UART_IDLE_LEVEL;
          if (pop) begin
            shift <= head;
            tx    <= ~UART_IDLE_LEVEL;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == BW'(N_data-1)) begin
              tx    <= UART_IDLE_LEVEL;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              shift <= head;
              tx    <= ~UART_IDLE_LEVEL;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_giraffe_uart_tx.sv
// Self-checking bench: per-cycle comparison of tx/uart_rdy/busy/ovf against a frame-timing model.
module tb_giraffe_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NB    = 8;
  localparam int FRAME = (NB + 2) * CPB;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic tx, busy, ovf;

  always #5 clk = ~clk;

  giraffe_uart_tx_if #(.N_data(NB)) bus ();

  giraffe_uart_tx #(.N_data(NB), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .tx   (tx),
    .busy (busy),
    .ovf  (ovf)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending bytes, start edge and byte of the frame currently on the line.
  logic [NB-1:0] q [$];
  int            edge_n = 0;
  int            cur_s;
  logic [NB-1:0] cur_d;
  bit            ovf_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_rst();
    q.delete();
    cur_s = edge_n - 2 * FRAME;
    cur_d = '0;
    ovf_m = 1'b0;
  endtask

  // Expected line level after edge edge_n: start 0, data LSB first, stop 1, else idle 1.
  function automatic logic exp_tx();
    int idx;
    if (edge_n < cur_s + FRAME) begin
      idx = (edge_n - cur_s) / CPB;
      if (idx == 0)  return 1'b0;
      if (idx <= NB) return cur_d[idx-1];
    end
    return 1'b1;
  endfunction

  function automatic bit model_idle();
    return (q.size() == 0) && (edge_n >= cur_s + FRAME);
  endfunction

  // One clock: drive, advance model with pre-edge state, then compare outputs.
  task automatic cyc(input logic w, input logic [NB-1:0] d);
    bit rdy;
    @(negedge clk);
    bus.wreq  = w;
    bus.wdata = w ? d : 'x;
    @(posedge clk);
    edge_n++;
    rdy = (q.size() != DEPTH);
    if (q.size() > 0 && edge_n >= cur_s + FRAME) begin
      cur_d = q.pop_front();
      cur_s = edge_n;
    end
    if (w) begin
      if (rdy) q.push_back(d);
      else     ovf_m = 1'b1;
    end
    #1;
    chk("tx",       tx,           exp_tx());
    chk("uart_rdy", bus.uart_rdy, q.size() != DEPTH);
    chk("busy",     busy,         !model_idle());
    chk("ovf",      ovf,          ovf_m);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      cyc(1'b0, '0);
      n++;
    end
    chk("drain_timeout", model_idle(), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.wreq = 1'b0;
    model_rst();
    repeat (3) @(negedge clk);
    chk("rst_tx",  tx,           1'b1);
    chk("rst_rdy", bus.uart_rdy, 1'b1);
    chk("rst_bsy", busy,         1'b0);
    chk("rst_ovf", ovf,          1'b0);
    nrst = 1'b1;
  endtask

  int rates [4] = '{5, 30, 2, 60};

  initial begin
    bus.wreq  = 1'b0;
    bus.wdata = '0;
    model_rst();
    do_reset();

    // Quiet line after reset.
    repeat (100) cyc(1'b0, '0);

    // Single byte, full frame timing.
    cyc(1'b1, 8'hA5);
    drain(200);

    // Five consecutive writes, all accepted, gapless frames.
    for (int i = 1; i <= 5; i++) begin
      chk("burst_rdy", bus.uart_rdy, 1'b1);
      cyc(1'b1, NB'(i));
    end
    chk("burst_ovf", ovf, 1'b0);
    drain(400);

    // Six consecutive writes: sixth is dropped.
    for (int i = 0; i < 6; i++) cyc(1'b1, NB'($urandom));
    chk("fill_ovf", ovf, 1'b1);
    drain(400);
    chk("ovf_sticky", ovf, 1'b1);

    // Fill, then push exactly on the STOP-end pop edge while full.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, NB'($urandom));
    chk("full_rdy", bus.uart_rdy, 1'b0);
    for (int n = 0; n < 100 && edge_n + 1 < cur_s + FRAME; n++) cyc(1'b0, '0);
    cyc(1'b1, 8'h3C);
    chk("popedge_rdy", bus.uart_rdy, 1'b1);
    chk("popedge_ovf", ovf,          1'b1);
    drain(400);

    // Random traffic at several write rates.
    do_reset();
    foreach (rates[r]) begin
      for (int n = 0; n < 300; n++)
        cyc(($urandom_range(0, 99) < rates[r]), NB'($urandom));
    end
    drain(600);

    // Reset in the middle of the data bits of an 0xFF frame.
    do_reset();
    cyc(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(1'b1, NB'($urandom));
    for (int n = 0; n < 100 && edge_n < cur_s + 3 * CPB + 2; n++) cyc(1'b0, '0);
    chk("mid_tx_hi", tx, 1'b1);
    #1 nrst = 1'b0;
    #1;
    chk("async_tx",  tx,           1'b1);
    chk("async_rdy", bus.uart_rdy, 1'b1);
    chk("async_bsy", busy,         1'b0);
    model_rst();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (100) cyc(1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
